// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS32 unified-memory arbiter and the core.
package mips_mem_pkg;

   localparam int ARB_AW_DEFAULT = 10;
   localparam int ARB_DW_DEFAULT = 32;

   // Opcode of HLT; the core decodes it to raise 'halted' towards the arbiter.
   localparam logic [5:0] HLT_OPCODE = 6'h3f;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } arb_state_t;

   typedef enum logic {
      OWN_IF,
      OWN_DM
   } owner_t;

endpackage

// File: rtl/mips_arb_lat_ctr.sv
// Loadable down-counter that times one fixed-latency memory access.
module mips_arb_lat_ctr #(
   parameter int MEM_LAT = 2
) (
   input  logic clk1,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic done
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = 4'(MEM_LAT);
      end else if (dec && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The edge that ends the count-1 cycle is the one on which read data is valid.
   assign done = dec && (cnt_q == 4'd1);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter between the IF and MEM stages of the MIPS32 core.
// Optional grant/wait statistics counters are built when MIPS_ARB_STATS_EN is defined.
module mips_mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int AW             = ARB_AW_DEFAULT,
   parameter int DW             = ARB_DW_DEFAULT,
   parameter int MEM_LAT        = 2,
   parameter int MAX_MEM_STREAK = 4
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_flush,
   input  logic          halted,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
`ifdef MIPS_ARB_STATS_EN
   ,
   output logic [31:0]   stat_if_grants,
   output logic [31:0]   stat_dm_grants,
   output logic [31:0]   stat_if_wait
`endif
);

   localparam int SW = $clog2(MAX_MEM_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);

   arb_state_t    state_q, state_d;
   owner_t        owner_q, owner_d;
   logic          store_q, store_d;
   logic          drop_q, drop_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          if_rvalid_q, if_rvalid_d;
   logic          dm_rvalid_q, dm_rvalid_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] dm_rdata_q, dm_rdata_d;

   logic if_elig;
   logic force_if;
   logic grant_if;
   logic grant_dm;
   logic lat_done;

   // Grant decision and memory strobes; gated by rst_n so reset drives every output low.
   always_comb begin
      if_elig  = if_req & ~halted & ~if_flush;
      force_if = if_elig & (streak_q == STREAK_MAX);
      grant_if = 1'b0;
      grant_dm = 1'b0;
      if (rst_n && (state_q == ARB_IDLE)) begin
         if (dm_req && !force_if) begin
            grant_dm = 1'b1;
         end else if (if_elig) begin
            grant_if = 1'b1;
         end
      end

      if_gnt    = grant_if;
      dm_gnt    = grant_dm;
      mem_en    = grant_if | grant_dm;
      mem_we    = grant_dm & dm_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_dm) begin
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (grant_if) begin
         mem_addr  = if_addr;
      end
   end

   mips_arb_lat_ctr #(
      .MEM_LAT (MEM_LAT)
   ) u_lat_ctr (
      .clk1  (clk1),
      .rst_n (rst_n),
      .load  (grant_if | grant_dm),
      .dec   (state_q == ARB_BUSY),
      .done  (lat_done)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      store_d     = store_q;
      drop_d      = drop_q;
      streak_d    = streak_q;
      if_rvalid_d = 1'b0;
      dm_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;

      case (state_q)
         ARB_IDLE: begin
            if (grant_dm) begin
               state_d = ARB_BUSY;
               owner_d = OWN_DM;
               store_d = dm_we;
               drop_d  = 1'b0;
               // The streak only grows while a fetch is actually being held off.
               if (if_elig) begin
                  streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
               end else begin
                  streak_d = '0;
               end
            end else if (grant_if) begin
               state_d  = ARB_BUSY;
               owner_d  = OWN_IF;
               store_d  = 1'b0;
               drop_d   = if_flush;
               streak_d = '0;
            end
         end

         ARB_BUSY: begin
            if ((owner_q == OWN_IF) && if_flush) begin
               drop_d = 1'b1;
            end
            if (lat_done) begin
               state_d = ARB_IDLE;
               drop_d  = 1'b0;
               if (owner_q == OWN_IF) begin
                  if (!drop_q && !if_flush) begin
                     if_rvalid_d = 1'b1;
                     if_rdata_d  = mem_rdata;
                  end
               end else begin
                  dm_rvalid_d = 1'b1;
                  if (!store_q) begin
                     dm_rdata_d = mem_rdata;
                  end
               end
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         owner_q     <= OWN_IF;
         store_q     <= 1'b0;
         drop_q      <= 1'b0;
         streak_q    <= '0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         store_q     <= store_d;
         drop_q      <= drop_d;
         streak_q    <= streak_d;
         if_rvalid_q <= if_rvalid_d;
         dm_rvalid_q <= dm_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rvalid = dm_rvalid_q;
   assign dm_rdata  = dm_rdata_q;
   assign busy      = (state_q == ARB_BUSY);

`ifdef MIPS_ARB_STATS_EN
   logic [31:0] stat_if_grants_q, stat_if_grants_d;
   logic [31:0] stat_dm_grants_q, stat_dm_grants_d;
   logic [31:0] stat_if_wait_q, stat_if_wait_d;

   // Wrapping event counters; a waiting cycle is an eligible fetch that was not granted.
   always_comb begin
      stat_if_grants_d = stat_if_grants_q + (grant_if ? 32'd1 : 32'd0);
      stat_dm_grants_d = stat_dm_grants_q + (grant_dm ? 32'd1 : 32'd0);
      stat_if_wait_d   = stat_if_wait_q + ((if_elig && !grant_if) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         stat_if_grants_q <= '0;
         stat_dm_grants_q <= '0;
         stat_if_wait_q   <= '0;
      end else begin
         stat_if_grants_q <= stat_if_grants_d;
         stat_dm_grants_q <= stat_dm_grants_d;
         stat_if_wait_q   <= stat_if_wait_d;
      end
   end

   assign stat_if_grants = stat_if_grants_q;
   assign stat_dm_grants = stat_dm_grants_q;
   assign stat_if_wait   = stat_if_wait_q;
`endif

endmodule
